// File: rtl/systolic_result_writer_pkg.sv
// Shared defaults and state encoding for the systolic result write-back path.
package systolic_result_writer_pkg;

  localparam int unsigned DefN          = 8;
  localparam int unsigned DefDataWidth  = 32;
  localparam int unsigned DefBandwidth  = 8;
  localparam int unsigned DefAddrWidth  = 32;
  localparam int unsigned DefDimWidth   = 16;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StDone
  } wr_state_e;

endpackage

// File: rtl/wb_row_addr_accum.sv
// Row address accumulator: loads a base address, then adds a fixed offset per enabled step.
module wb_row_addr_accum
  import systolic_result_writer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] offset_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = base_i;
    end else if (en_i) begin
      addr_d = addr_q + offset_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/systolic_result_writer.sv
// Snapshots the systolic tile result on start and streams it row by row to memory.
module systolic_result_writer
  import systolic_result_writer_pkg::*;
#(
  parameter int unsigned N          = DefN,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned BANDWIDTH  = DefBandwidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DIM_WIDTH  = DefDimWidth
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [N*N*DATA_WIDTH-1:0]       result,
  input  logic [ADDR_WIDTH-1:0]           base_C,
  input  logic [DIM_WIDTH-1:0]            dim_col_C,
  input  logic [DIM_WIDTH-1:0]            n_rows,
  input  logic [DIM_WIDTH-1:0]            n_cols,
  input  logic                            waitrequest,
  output logic                            write,
  output logic [ADDR_WIDTH-1:0]           write_addr,
  output logic [BANDWIDTH*DATA_WIDTH-1:0] writedata,
  output logic [BANDWIDTH-1:0]            write_mask,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned Beats = N / BANDWIDTH;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned RowW  = $clog2(N + 1);
  localparam int unsigned IdxW  = $clog2(N * N);
  localparam int unsigned ColW  = DIM_WIDTH + 1;
  localparam logic [DIM_WIDTH-1:0] NDim = DIM_WIDTH'(N);

  wr_state_e                          state_q, state_d;
  logic [RowW-1:0]                    r_q, r_d;
  logic [BeatW-1:0]                   b_q, b_d;
  logic [DIM_WIDTH-1:0]               stride_q, stride_d;
  logic [DIM_WIDTH-1:0]               n_rows_q, n_rows_d;
  logic [DIM_WIDTH-1:0]               n_cols_q, n_cols_d;
  logic [N*N-1:0][DATA_WIDTH-1:0]     snap_q, snap_d;

  logic [DIM_WIDTH-1:0]  n_rows_clamp, n_cols_clamp;
  logic [ColW-1:0]       col_base, lane_col;
  logic                  row_end, last_row;
  logic                  addr_load, addr_en;
  logic [ADDR_WIDTH-1:0] row_addr, stride_ext;

  assign n_rows_clamp = (n_rows > NDim) ? NDim : n_rows;
  assign n_cols_clamp = (n_cols > NDim) ? NDim : n_cols;
  assign stride_ext   = ADDR_WIDTH'(stride_q);

  assign col_base = ColW'(b_q) * ColW'(BANDWIDTH);
  // A row ends at its last beat or at the last beat holding any valid column; the
  // all-masked beats after it are skipped without costing a cycle.
  assign row_end  = (b_q == BeatW'(Beats - 1)) ||
                    ((col_base + ColW'(BANDWIDTH)) >= {1'b0, n_cols_q});
  assign last_row = (DIM_WIDTH'(r_q) == (n_rows_q - DIM_WIDTH'(1)));

  wb_row_addr_accum #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_row_addr (
    .clock   (clock),
    .reset   (reset),
    .load_i  (addr_load),
    .base_i  (base_C),
    .en_i    (addr_en),
    .offset_i(stride_ext),
    .addr_o  (row_addr)
  );

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    b_d        = b_q;
    stride_d   = stride_q;
    n_rows_d   = n_rows_q;
    n_cols_d   = n_cols_q;
    snap_d     = snap_q;
    addr_load  = 1'b0;
    addr_en    = 1'b0;
    write      = 1'b0;
    write_addr = '0;
    writedata  = '0;
    write_mask = '0;
    done       = 1'b0;
    lane_col   = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          snap_d    = result;
          stride_d  = dim_col_C;
          n_rows_d  = n_rows_clamp;
          n_cols_d  = n_cols_clamp;
          r_d       = '0;
          b_d       = '0;
          addr_load = 1'b1;
          if ((n_rows_clamp == '0) || (n_cols_clamp == '0)) begin
            state_d = StDone;
          end else begin
            state_d = StWrite;
          end
        end
      end

      StWrite: begin
        write      = 1'b1;
        write_addr = row_addr + ADDR_WIDTH'(col_base);
        for (int m = 0; m < int'(BANDWIDTH); m++) begin
          lane_col      = col_base + ColW'(m);
          write_mask[m] = (lane_col < {1'b0, n_cols_q});
          writedata[m*DATA_WIDTH +: DATA_WIDTH] =
            snap_q[IdxW'(int'(r_q) * int'(N) + int'(b_q) * int'(BANDWIDTH) + m)];
        end
        if (!waitrequest) begin
          if (row_end) begin
            b_d     = '0;
            r_d     = r_q + RowW'(1);
            addr_en = 1'b1;
            if (last_row) begin
              state_d = StDone;
            end
          end else begin
            b_d = b_q + BeatW'(1);
          end
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      r_q      <= '0;
      b_q      <= '0;
      stride_q <= '0;
      n_rows_q <= '0;
      n_cols_q <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      b_q      <= b_d;
      stride_q <= stride_d;
      n_rows_q <= n_rows_d;
      n_cols_q <= n_cols_d;
    end
  end

  // Snapshot contents are irrelevant until the next start, so they carry no reset.
  always_ff @(posedge clock) begin
    snap_q <= snap_d;
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_systolic_result_writer.sv
// Randomized self-checking bench for systolic_result_writer against a beat-list model.
module tb_systolic_result_writer;

  localparam int N   = 8;
  localparam int DW  = 32;
  localparam int BW  = 8;
  localparam int AW  = 32;
  localparam int DMW = 16;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 waitrequest = 1'b0;
  logic [N*N*DW-1:0]    result = '0;
  logic [AW-1:0]        base_C = '0;
  logic [DMW-1:0]       dim_col_C = '0;
  logic [DMW-1:0]       n_rows = '0;
  logic [DMW-1:0]       n_cols = '0;
  logic                 write;
  logic [AW-1:0]        write_addr;
  logic [BW*DW-1:0]     writedata;
  logic [BW-1:0]        write_mask;
  logic                 busy;
  logic                 done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mat [N][N];

  always #5 clock = ~clock;

  systolic_result_writer dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .result     (result),
    .base_C     (base_C),
    .dim_col_C  (dim_col_C),
    .n_rows     (n_rows),
    .n_cols     (n_cols),
    .waitrequest(waitrequest),
    .write      (write),
    .write_addr (write_addr),
    .writedata  (writedata),
    .write_mask (write_mask),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [31:0] to_fp32(input int v);
    int          e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic logic [N*N*DW-1:0] pack_mat();
    logic [N*N*DW-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        v[(r*N + c)*DW +: DW] = mat[r][c];
    return v;
  endfunction

  task automatic fill_ramp();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = to_fp32(r*8 + c);
  endtask

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = $urandom();
  endtask

  // One transfer: the model lists every expected beat, then the loop drives waitrequest
  // and compares each observed cycle against that list and the expected done cycle.
  task automatic run_xfer(input string name, input int nr, input int nc,
                          input logic [31:0] base, input logic [15:0] stride,
                          input int st_a, input int st_b, input int st_len,
                          input int disturb_beat, input int reset_beat);
    int          rr, cc, nbeats, exp_done, cyc, beat, stall_left;
    bit          disturbed;
    logic [31:0]  q_addr [$];
    logic [255:0] q_data [$];
    logic [7:0]   q_mask [$];
    logic [255:0] d;
    logic [7:0]   mk;

    rr = (nr > N) ? N : nr;
    cc = (nc > N) ? N : nc;
    for (int r = 0; r < rr; r++) begin
      for (int b = 0; b < N / BW; b++) begin
        if (b * BW < cc) begin
          for (int m = 0; m < BW; m++) begin
            d[m*DW +: DW] = mat[r][b*BW + m];
            mk[m]         = (b*BW + m < cc);
          end
          q_addr.push_back(base + 32'(r) * {16'h0, stride} + 32'(b * BW));
          q_data.push_back(d);
          q_mask.push_back(mk);
        end
      end
    end
    nbeats   = q_addr.size();
    exp_done = 1 + nbeats + ((st_a < nbeats) ? st_len : 0)
             + ((st_b < nbeats && st_b != st_a) ? st_len : 0);

    @(negedge clock);
    start       = 1'b1;
    result      = pack_mat();
    base_C      = base;
    dim_col_C   = stride;
    n_rows      = 16'(nr);
    n_cols      = 16'(nc);
    waitrequest = 1'b0;
    cyc         = 0;
    beat        = 0;
    disturbed   = 1'b0;
    stall_left  = (st_a == 0 || st_b == 0) ? st_len : 0;

    forever begin
      @(negedge clock);
      cyc++;
      start       = 1'b0;
      waitrequest = 1'b0;
      if (cyc > 300) begin
        n_checks++; n_fail++;
        $display("FAIL %s timeout: no done after %0d cycles, want done at %0d", name, cyc,
                 exp_done);
        break;
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d: got %b want 1", name, cyc, busy);
      end
      if (write === 1'b1) begin
        if (beat == reset_beat) begin
          reset = 1'b1;
          #1;
          n_checks++;
          if (write !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s async reset: got write=%b busy=%b done=%b want 0 0 0", name,
                     write, busy, done);
          end
          @(negedge clock);
          reset = 1'b0;
          repeat (3) begin
            @(negedge clock);
            n_checks++;
            if (write !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
              n_fail++;
              $display("FAIL %s after reset: got write=%b done=%b busy=%b want 0 0 0", name,
                       write, done, busy);
            end
          end
          return;
        end
        if (beat == disturb_beat && !disturbed) begin
          disturbed = 1'b1;
          result    = {64{$urandom()}};
          base_C    = base ^ 32'hFFFF_0000;
          start     = 1'b1;
        end
        n_checks++;
        if (beat >= nbeats) begin
          n_fail++;
          $display("FAIL %s extra beat: got beat %0d want only %0d beats", name, beat, nbeats);
        end else if (write_addr !== q_addr[beat] || writedata !== q_data[beat] ||
                     write_mask !== q_mask[beat]) begin
          n_fail++;
          $display("FAIL %s beat %0d: got addr=%h mask=%h data=%h want addr=%h mask=%h data=%h",
                   name, beat, write_addr, write_mask, writedata, q_addr[beat], q_mask[beat],
                   q_data[beat]);
        end
        if (stall_left > 0) begin
          waitrequest = 1'b1;
          stall_left--;
        end else begin
          beat++;
          stall_left = (beat == st_a || beat == st_b) ? st_len : 0;
        end
      end
      if (done === 1'b1) begin
        n_checks++;
        if (cyc != exp_done || beat != nbeats) begin
          n_fail++;
          $display("FAIL %s done: got cycle %0d beats %0d want cycle %0d beats %0d", name, cyc,
                   beat, exp_done, nbeats);
        end
        break;
      end
    end

    repeat (3) begin
      @(negedge clock);
      n_checks++;
      if (done !== 1'b0 || write !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle after done: got done=%b write=%b busy=%b want 0 0 0", name, done,
                 write, busy);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_checks++;
    if (write !== 1'b0 || write_addr !== '0 || writedata !== '0 || write_mask !== '0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got write=%b addr=%h mask=%h busy=%b done=%b want all 0",
               write, write_addr, write_mask, busy, done);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_full_tile();
    fill_ramp();
    run_xfer("full", 8, 8, 32'h100, 16'd8, -1, -1, 0, -1, -1);
  endtask

  task automatic test_stalls();
    fill_ramp();
    run_xfer("stall", 8, 8, 32'h100, 16'd8, 0, 5, 3, -1, -1);
  endtask

  task automatic test_partial();
    fill_random();
    run_xfer("partial", 5, 3, 32'h0, 16'd20, -1, -1, 0, -1, -1);
    run_xfer("clamp", 9, 12, 32'h40, 16'd16, -1, -1, 0, -1, -1);
  endtask

  task automatic test_degenerate();
    fill_random();
    run_xfer("zero_rows", 0, 8, 32'h10, 16'd8, -1, -1, 0, -1, -1);
    run_xfer("zero_cols", 4, 0, 32'h10, 16'd8, -1, -1, 0, -1, -1);
  endtask

  task automatic test_isolation();
    fill_ramp();
    run_xfer("isolate", 8, 8, 32'h200, 16'd8, -1, -1, 0, 2, -1);
  endtask

  task automatic test_reset_mid();
    fill_random();
    run_xfer("reset_mid", 8, 8, 32'h100, 16'd8, -1, -1, 0, -1, 4);
    fill_random();
    run_xfer("post_reset", 8, 8, 32'h300, 16'd12, -1, -1, 0, -1, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      fill_random();
      run_xfer("random", int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
               (i % 2 == 0) ? 32'hFFFF_FF00 + $urandom_range(0, 255) : $urandom(),
               16'($urandom_range(0, 65535)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_full_tile();
    test_stalls();
    test_partial();
    test_degenerate();
    test_isolation();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_result_writer.md
Name: systolic_result_writer

Overview:
- Write-back engine for the 8x8 systolic array tile result.
- On start, snapshots the N x N result matrix and writes it row by row to memory in BANDWIDTH-wide beats.
- Uses a base address and row stride, mirroring how the driver fetches A/B rows.
- Sits between the systolic array's Out bus and the shared memory write port; frees the array for the next tile as soon as the snapshot is taken.

Parameters:
- N, 8, tile dimension (rows and columns of the result).
- DATA_WIDTH, 32, element width (fp32).
- BANDWIDTH, 8, elements per memory beat; N must be a multiple of BANDWIDTH.
- ADDR_WIDTH, 32, element address width.
- DIM_WIDTH, 16, width of stride and dimension inputs.

Ports:
- clock  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- result  input  N*N*DATA_WIDTH  tile result, [row][col] packed, as produced by the systolic array.
- base_C  input  ADDR_WIDTH  element address of row 0, column 0.
- dim_col_C  input  DIM_WIDTH  row stride in elements.
- n_rows  input  DIM_WIDTH  valid rows; values greater than N are clamped to N.
- n_cols  input  DIM_WIDTH  valid columns; values greater than N are clamped to N.
- waitrequest  input  1  memory stall; a beat is accepted when write is high and waitrequest is low.
- write  output  1  write request.
- write_addr  output  ADDR_WIDTH  beat element address.
- writedata  output  BANDWIDTH*DATA_WIDTH  beat data; lane m carries column b*BANDWIDTH+m.
- write_mask  output  BANDWIDTH  per-lane enable; lane m is set iff column index < n_cols.
- busy  output  1  high from the cycle after start is accepted through the done cycle.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE.
  - Outputs: write=0, write_addr=0, writedata=0, write_mask=0, busy=0, done=0.
  - Snapshot buffer contents are don't-care.
- States: IDLE, WRITE, DONE.
- IDLE:
  - On start, on the same edge, register the snapshot of result, base_C, dim_col_C and clamped n_rows/n_cols.
  - Clear row index r=0, beat index b=0, and set row_addr=base_C.
  - If clamped n_rows==0 or n_cols==0, go to DONE with no writes. Otherwise go to WRITE.
- WRITE:
  - write=1; write_addr = row_addr + b*BANDWIDTH.
  - writedata = snapshot row r, columns b*BANDWIDTH .. b*BANDWIDTH+BANDWIDTH-1.
  - write_mask is derived from n_cols.
  - Address, data and mask hold stable while waitrequest=1.
  - On accept:
    - If b < N/BANDWIDTH-1, then b++.
    - Else set b=0, r++, row_addr += dim_col_C.
    - If the accepted beat was the last beat of row n_rows-1, go to DONE.
  - Beats whose mask would be all-zero (b*BANDWIDTH ≥ n_cols) are skipped: advance to the next row without asserting write.
- DONE: done=1 for exactly one cycle, write=0, then return to IDLE. busy falls the cycle after DONE.
- Latency: with waitrequest=0, the first write is asserted the cycle after start. Total beats = n_rows*ceil(n_cols/BANDWIDTH). The done pulse comes one cycle after the final accept.
- Address arithmetic: modulo 2^ADDR_WIDTH; wrap is silent. dim_col_C is zero-extended.
- start while busy: ignored; the snapshot is not disturbed.
- Changes to result or base inputs after the start edge have no effect on the current transfer.
- Reset mid-transfer: immediate return to IDLE, write drops asynchronously, no done pulse, remaining beats are abandoned.
- start and reset asserted together: reset wins.

Decomposition:
- Shared package (the existing macro header):
  - DATA_WIDTH, BANDWIDTH, ADDR_WIDTH and DIM_WIDTH defaults.
  - The writer state enum.
- Sub-module: wb_row_addr_accum.
  - Loads base_C, adds dim_col_C per row.
  - Same load/en/offset structure as the driver's address accumulators.
- Everything else stays inline.

Test Plan:
- Full tile, no stall: result[r][c]=r*8+c as fp32, base_C=0x100, dim_col_C=8, n_rows=n_cols=8, waitrequest=0.
  - Expect 8 writes on consecutive cycles at 0x100, 0x108 … 0x138.
  - Mask 0xFF; lane m of beat r = r*8+m.
  - done is asserted 9 cycles after start.
- Stalls: same stimulus, waitrequest high for 3 cycles on beats 0 and 5.
  - addr/data/mask held constant while stalled; no duplicate or missing beats.
  - done is asserted 15 cycles after start.
- Partial tile: n_rows=5, n_cols=3, dim_col_C=20, base_C=0.
  - Expect 5 writes at 0, 20, 40, 60, 80 with mask 0x07.
  - n_rows=9 clamps to 8 writes.
- Degenerate: n_rows=0 or n_cols=0.
  - No write; done is asserted 1 cycle after start (DONE state), busy high for that single cycle.
- Snapshot/start isolation: change result and base_C and pulse start during beat 2.
  - All 8 beats carry the original data and addresses; exactly one done.
- Reset mid-transfer: assert reset during beat 4.
  - write drops immediately and no done is asserted.
  - A subsequent start performs a complete, correct 8-beat transfer.
